// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with per-digit BCD counting, pause toggle and a field-adjust mode.
// Digits, state and the running flag are all flops, so every output is registered.
module stopwatch_counter #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       adj_tick,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [4:0] min_l,
    output logic [4:0] min_r,
    output logic [4:0] sec_l,
    output logic [4:0] sec_r,
    output logic       running
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic [3:0] MIN_LIM_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_LIM_O = 4'(MIN_LIMIT % 10);

    state_t     state_q, state_n;
    logic       pause_q;
    logic       pause_evt;
    logic       running_q;
    logic [3:0] min_l_q, min_r_q, sec_r_q;
    logic [2:0] sec_l_q;
    logic [3:0] min_l_n, min_r_n, sec_r_n;
    logic [2:0] sec_l_n;
    logic [7:0] min_inc, sec_inc;
    logic       sec_at_max;

    // Two-digit BCD increment that wraps to 00 once the pair equals the limit.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic [3:0] lim_t, input logic [3:0] lim_o);
        if (tens == lim_t && ones == lim_o)
            return 8'h00;
        else if (ones == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, ones + 4'd1};
    endfunction

    assign pause_evt  = pause & ~pause_q;
    assign min_inc    = bcd_inc(min_l_q, min_r_q, MIN_LIM_T, MIN_LIM_O);
    assign sec_inc    = bcd_inc({1'b0, sec_l_q}, sec_r_q, 4'd5, 4'd9);
    assign sec_at_max = (sec_l_q == 3'd5) && (sec_r_q == 4'd9);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state_q;
        if (adj) begin
            state_n = ST_ADJUST;
        end else begin
            unique case (state_q)
                ST_RUN:    if (pause_evt) state_n = ST_PAUSED;
                ST_PAUSED: if (pause_evt) state_n = ST_RUN;
                ST_ADJUST: state_n = ST_PAUSED;
                default:   state_n = ST_PAUSED;
            endcase
        end
    end

    // Counting keys off the current state, so a tick coinciding with a pause event still counts.
    always_comb begin
        min_l_n = min_l_q;
        min_r_n = min_r_q;
        sec_l_n = sec_l_q;
        sec_r_n = sec_r_q;
        if (state_q == ST_RUN && tick) begin
            sec_l_n = sec_inc[6:4];
            sec_r_n = sec_inc[3:0];
            if (sec_at_max) begin
                min_l_n = min_inc[7:4];
                min_r_n = min_inc[3:0];
            end
        end else if (state_q == ST_ADJUST && adj_tick) begin
            if (sel) begin
                sec_l_n = sec_inc[6:4];
                sec_r_n = sec_inc[3:0];
            end else begin
                min_l_n = min_inc[7:4];
                min_r_n = min_inc[3:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PAUSED;
            running_q <= 1'b0;
            pause_q   <= pause;
            min_l_q   <= '0;
            min_r_q   <= '0;
            sec_l_q   <= '0;
            sec_r_q   <= '0;
        end else begin
            state_q   <= state_n;
            running_q <= (state_n == ST_RUN);
            pause_q   <= pause;
            min_l_q   <= min_l_n;
            min_r_q   <= min_r_n;
            sec_l_q   <= sec_l_n;
            sec_r_q   <= sec_r_n;
        end
    end

    assign min_l   = {1'b0, min_l_q};
    assign min_r   = {1'b0, min_r_q};
    assign sec_l   = {2'b00, sec_l_q};
    assign sec_r   = {1'b0, sec_r_q};
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: stimulus pushes expected MM:SS/running into a queue, a negedge monitor compares.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst, tick, adj_tick, pause, adj, sel;
    logic [4:0] min_l, min_r, sec_l, sec_r;
    logic       running;

    typedef struct {
        string      name;
        logic [4:0] ml, mr, sl, sr;
        logic       run;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    stopwatch_counter #(.MIN_LIMIT(59)) dut (
        .clk(clk), .rst(rst), .tick(tick), .adj_tick(adj_tick), .pause(pause),
        .adj(adj), .sel(sel), .min_l(min_l), .min_r(min_r), .sec_l(sec_l),
        .sec_r(sec_r), .running(running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        tick     = 1'b0;
        adj_tick = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic expect_t(input string name, input int mm, input int ss, input logic run);
        exp_t e;
        e.name = name;
        e.ml   = 5'(mm / 10);
        e.mr   = 5'(mm % 10);
        e.sl   = 5'(ss / 10);
        e.sr   = 5'(ss % 10);
        e.run  = run;
        sb_q.push_back(e);
    endtask

    task automatic tick_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            step();
        end
    endtask

    task automatic adj_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            adj_tick = 1'b1;
            step();
            step();
        end
    endtask

    task automatic pause_pulse(input string name, input int mm, input int ss, input logic run);
        pause = 1'b1;
        step();
        expect_t(name, mm, ss, run);
        pause = 1'b0;
        step();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if ({min_l, min_r, sec_l, sec_r, running} !== {e.ml, e.mr, e.sl, e.sr, e.run}) begin
                bad++;
                $display("FAIL %s: got %0d%0d:%0d%0d running=%0b, want %0d%0d:%0d%0d running=%0b",
                         e.name, min_l, min_r, sec_l, sec_r, running,
                         e.ml, e.mr, e.sl, e.sr, e.run);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; adj_tick = 1'b0; pause = 1'b0; adj = 1'b0; sel = 1'b0;
        step();
        expect_t("reset", 0, 0, 1'b0);

        // Run from reset for 61 seconds.
        pause_pulse("run_entry", 0, 0, 1'b1);
        for (int i = 1; i <= 61; i++) begin
            tick = 1'b1;
            step();
            if (i == 10) expect_t("tick10", 0, 10, 1'b1);
            if (i == 60) expect_t("sec_carry", 1, 0, 1'b1);
            if (i == 61) expect_t("count_61", 1, 1, 1'b1);
            step();
        end

        // Pause holds the time and ignores ticks; a second pause event resumes.
        rst = 1'b1;
        step();
        expect_t("reset2", 0, 0, 1'b0);
        pause_pulse("run2", 0, 0, 1'b1);
        tick_pulses(10);
        expect_t("at_0010", 0, 10, 1'b1);
        pause_pulse("pause_hold", 0, 10, 1'b0);
        tick_pulses(5);
        expect_t("paused_ignores_tick", 0, 10, 1'b0);
        pause_pulse("resume", 0, 10, 1'b1);
        tick = 1'b1;
        step();
        expect_t("resume_tick", 0, 11, 1'b1);

        // Tick and pause event together: count first, then pause.
        pause = 1'b1;
        tick  = 1'b1;
        step();
        expect_t("tick_and_pause", 0, 12, 1'b0);
        pause = 1'b0;
        step();

        // Adjust-mode field increments and wraps, then run 59:59 over to 00:00.
        adj = 1'b1;
        sel = 1'b0;
        step();
        expect_t("enter_adjust", 0, 12, 1'b0);
        adj_pulses(59);
        expect_t("adj_min", 59, 12, 1'b0);
        sel = 1'b1;
        step();
        expect_t("sel_change", 59, 12, 1'b0);
        adj_pulses(47);
        expect_t("adj_sec", 59, 59, 1'b0);
        adj_pulses(1);
        expect_t("sec_wrap", 59, 0, 1'b0);
        adj_pulses(59);
        sel = 1'b0;
        adj_pulses(1);
        expect_t("min_wrap", 0, 59, 1'b0);
        adj_pulses(59);
        adj = 1'b0;
        step();
        expect_t("adjust_exit", 59, 59, 1'b0);
        pause_pulse("run_5959", 59, 59, 1'b1);
        tick = 1'b1;
        step();
        expect_t("full_wrap", 0, 0, 1'b1);

        // Coincident tick and adj_tick in adjust; pause events ignored there.
        adj = 1'b1;
        step();
        expect_t("adjust_from_run", 0, 0, 1'b0);
        tick     = 1'b1;
        adj_tick = 1'b1;
        step();
        expect_t("tick_adj_coincide", 1, 0, 1'b0);
        tick = 1'b1;
        step();
        expect_t("adjust_ignores_tick", 1, 0, 1'b0);
        pause_pulse("adjust_ignores_pause", 1, 0, 1'b0);
        adj_tick = 1'b1;
        step();
        expect_t("still_adjust", 2, 0, 1'b0);
        adj = 1'b0;
        step();
        expect_t("exit_paused", 2, 0, 1'b0);

        // Reset samples pause into pause_q: a held-high pause is not an event.
        pause = 1'b1;
        rst   = 1'b1;
        step();
        expect_t("reset_pause_high", 0, 0, 1'b0);
        step();
        expect_t("no_evt_after_reset", 0, 0, 1'b0);
        pause = 1'b0;
        step();
        pause_pulse("first_evt_run", 0, 0, 1'b1);

        // Reset beats a tick while running.
        adj = 1'b1;
        step();
        sel = 1'b0;
        adj_pulses(9);
        sel = 1'b1;
        adj_pulses(58);
        adj = 1'b0;
        step();
        pause_pulse("run_0958", 9, 58, 1'b1);
        tick = 1'b1;
        step();
        expect_t("to_0959", 9, 59, 1'b1);
        step();
        tick = 1'b1;
        rst  = 1'b1;
        step();
        expect_t("reset_over_tick", 0, 0, 1'b0);

        // Minutes tens carry, then reset while adjusting.
        adj = 1'b1;
        step();
        sel = 1'b0;
        adj_pulses(9);
        sel = 1'b1;
        adj_pulses(59);
        adj = 1'b0;
        step();
        pause_pulse("run_0959", 9, 59, 1'b1);
        tick = 1'b1;
        step();
        expect_t("min_tens_carry", 10, 0, 1'b1);
        adj = 1'b1;
        step();
        adj_pulses(3);
        expect_t("adj_1003", 10, 3, 1'b0);
        adj_tick = 1'b1;
        rst      = 1'b1;
        step();
        expect_t("reset_in_adjust", 0, 0, 1'b0);
        adj = 1'b0;
        step();

        step();
        step();
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
